// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM fetch/decode front end.
package arm_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO between IF and the IF/ID register; a taken branch (flush)
// discards every buffered entry so wrong-path instructions never reach decode.
module if_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = arm_pkg::WORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [WORD_W-1:0]          pc_in,
    input  logic [WORD_W-1:0]          instruction_in,
    output logic                       ready_out,
    input  logic                       freeze,
    input  logic                       flush,
    output logic                       valid,
    output logic [WORD_W-1:0]          pc,
    output logic [WORD_W-1:0]          instruction,
    output logic [$clog2(DEPTH):0]     count
);
    import arm_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;

    // Handshake: a full queue still accepts when its head leaves this cycle.
    always_comb begin
        valid       = (count != '0);
        pc          = WORD_W'(INSTR_NOP);
        instruction = WORD_W'(INSTR_NOP);
        if (valid) begin
            pc          = mem[rd_ptr].pc;
            instruction = mem[rd_ptr].instruction;
        end
        pop       = valid & ~freeze & ~flush;
        ready_out = (count < CNT_W'(DEPTH)) | pop;
        push      = valid_in & ready_out & ~flush;
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: pc_in, instruction: instruction_in};
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and pseudo-random bench for if_fetch_queue with a queue-based reference model.
`timescale 1ns/1ps
module tb_if_fetch_queue;
    import arm_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        ready_out;
    logic        freeze;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t model_q[$];

    if_fetch_queue #(.DEPTH(DEPTH), .WORD_W(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
        .instruction_in(instruction_in), .ready_out(ready_out),
        .freeze(freeze), .flush(flush), .valid(valid), .pc(pc),
        .instruction(instruction), .count(count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        int n = model_q.size();
        return (n < DEPTH) || (n != 0 && !freeze && !flush);
    endfunction

    // Reference model: a FIFO of entries, emptied by reset or flush.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            logic do_pop, do_push;
            do_pop  = (model_q.size() != 0) && !freeze;
            do_push = valid_in && model_ready();
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: pc_in, instruction: instruction_in});
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        e_valid = (model_q.size() != 0);
        e_pc    = e_valid ? model_q[0].pc : 32'h0;
        e_instr = e_valid ? model_q[0].instruction : 32'h0;
        chk("model_valid", 64'(valid), 64'(e_valid));
        chk("model_pc", 64'(pc), 64'(e_pc));
        chk("model_instr", 64'(instruction), 64'(e_instr));
        chk("model_count", 64'(count), 64'(model_q.size()));
        chk("model_ready", 64'(ready_out), 64'(model_ready()));
    end

    // Apply inputs for one clock edge, then return just after that edge.
    task automatic drive(input logic vi, input logic [31:0] p, input logic [31:0] ins,
                         input logic frz, input logic fl);
        valid_in       = vi;
        pc_in          = p;
        instruction_in = ins;
        freeze         = frz;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input logic v, input logic [31:0] p,
                            input logic [31:0] ins, input logic [2:0] c);
        chk({name, "_valid"}, 64'(valid), 64'(v));
        chk({name, "_pc"}, 64'(pc), 64'(p));
        chk({name, "_instr"}, 64'(instruction), 64'(ins));
        chk({name, "_count"}, 64'(count), 64'(c));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; pc_in = '0; instruction_in = '0;
        freeze = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_head("reset", 1'b0, 32'h0, 32'h0, 3'd0);
        chk("reset_ready", 64'(ready_out), 64'(1));

        // 1: fill under freeze
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'(4 * i), 32'hE3A0_0000 + 32'(i), 1'b1, 1'b0);
        chk_head("fill", 1'b1, 32'd4, 32'hE3A0_0001, 3'd4);
        chk("fill_ready", 64'(ready_out), 64'(0));

        // 2: drain in order
        for (int i = 1; i <= 4; i++) begin
            valid_in = 1'b0; freeze = 1'b0;
            #1 chk_head("drain", 1'b1, 32'(4 * i), 32'hE3A0_0000 + 32'(i), 3'(5 - i));
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        chk_head("drained", 1'b0, 32'h0, 32'h0, 3'd0);

        // 3: full queue, simultaneous push and pop, wr_ptr wraps
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'(4 * i), 32'hE3A0_0000 + 32'(i), 1'b1, 1'b0);
        valid_in = 1'b1; pc_in = 32'd20; instruction_in = 32'hE3A0_0005; freeze = 1'b0;
        #1 chk("full_pop_ready", 64'(ready_out), 64'(1));
        drive(1'b1, 32'd20, 32'hE3A0_0005, 1'b0, 1'b0);
        chk_head("pushpop", 1'b1, 32'd8, 32'hE3A0_0002, 3'd4);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_head("tail", 1'b1, 32'd20, 32'hE3A0_0005, 3'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 4: flush drops the offered entry
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h30 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
        drive(1'b1, 32'h100, 32'hBEEF, 1'b0, 1'b1);
        chk_head("flush", 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 32'h200, 32'hCAFE, 1'b0, 1'b0);
        chk_head("after_flush", 1'b1, 32'h200, 32'hCAFE, 3'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 5: flush during freeze at full
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0);
        chk("full_freeze_count", 64'(count), 64'(4));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("flush_freeze_count", 64'(count), 64'(0));
        chk("flush_freeze_ready", 64'(ready_out), 64'(1));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 6: async reset between edges
        drive(1'b1, 32'h50, 32'hC0, 1'b1, 1'b0);
        drive(1'b1, 32'h54, 32'hC1, 1'b1, 1'b0);
        chk("pre_reset_count", 64'(count), 64'(2));
        #2 rst = 1'b1;
        #1 chk_head("async_reset", 1'b0, 32'h0, 32'h0, 3'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Pseudo-random traffic; the every-cycle compare checks it.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
